// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: debounces a 6-digit seven-segment sel/seg bus and decodes it back to hex digits.
// Ports: sys_clk, sys_rst_n (async, active-low); sel[5:0] digit selects; seg[7:0] active-low segments
// (bit7 = dp); digits[23:0] decoded nibbles; dig_valid[5:0]; dp[5:0] only with SEG_DP_CAPTURE_EN;
// frame_done and code_err are one-cycle pulses on commit. Optional macro: SEG_DP_CAPTURE_EN.
module seg_scan_decoder #(
  parameter logic [7:0] STABLE_MAX = 8'd15
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [5:0]  sel,
  input  logic [7:0]  seg,
  output logic [23:0] digits,
  output logic [5:0]  dig_valid,
`ifdef SEG_DP_CAPTURE_EN
  output logic [5:0]  dp,
`endif
  output logic        frame_done,
  output logic        code_err
);
  // returns {legal, blank, value}
  function automatic logic [5:0] dec(input logic [7:0] c);
    case (c | 8'h80)
      8'hc0: dec = 6'h20;
      8'hf9: dec = 6'h21;
      8'ha4: dec = 6'h22;
      8'hb0: dec = 6'h23;
      8'h99: dec = 6'h24;
      8'h92: dec = 6'h25;
      8'h82: dec = 6'h26;
      8'hf8: dec = 6'h27;
      8'h80: dec = 6'h28;
      8'h90: dec = 6'h29;
      8'h88: dec = 6'h2a;
      8'h83: dec = 6'h2b;
      8'hc6: dec = 6'h2c;
      8'ha1: dec = 6'h2d;
      8'h86: dec = 6'h2e;
      8'h8e: dec = 6'h2f;
      8'hff: dec = 6'h10;
      default: dec = 6'h00;
    endcase
  endfunction
  logic [13:0] s_q;
  logic [7:0]  stab_q, stab_d;
  logic [5:0]  seen_q, seen_d, valid_q, valid_d, dp_q, dp_d;
  logic [23:0] digits_q, digits_d;
  logic        frame_q, frame_d, err_q, err_d;
  logic        same, commit, any_sel, full;
  logic [5:0]  code;
  always_comb begin
    same     = {sel, seg} == s_q;
    stab_d   = !same ? 8'd0 : (stab_q == STABLE_MAX ? stab_q : stab_q + 8'd1);
    // saturation at STABLE_MAX makes this true only once per stable pattern
    commit   = same && stab_q == STABLE_MAX - 8'd1;
    code     = dec(s_q[7:0]);
    any_sel  = |s_q[13:8];
    full     = (seen_q | s_q[13:8]) == 6'h3f;
    digits_d = digits_q;
    valid_d  = valid_q;
    dp_d     = dp_q;
    for (int i = 0; i < 6; i++) begin
      if (commit && s_q[8+i]) begin
        digits_d[4*i +: 4] = code[5] ? code[3:0] : (code[4] ? 4'h0 : digits_q[4*i +: 4]);
        valid_d[i]         = code[5];
        dp_d[i]            = ~s_q[7];
      end
    end
    err_d   = commit && any_sel && !code[5] && !code[4];
    frame_d = commit && any_sel && full;
    seen_d  = commit ? (full ? 6'h00 : seen_q | s_q[13:8]) : seen_q;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s_q      <= {6'h00, 8'hff};
      stab_q   <= 8'd0;
      seen_q   <= 6'h00;
      digits_q <= 24'h0;
      valid_q  <= 6'h00;
      dp_q     <= 6'h00;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_q      <= {sel, seg};
      stab_q   <= stab_d;
      seen_q   <= seen_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end
  assign digits     = digits_q;
  assign dig_valid  = valid_q;
  assign frame_done = frame_q;
  assign code_err   = err_q;
`ifdef SEG_DP_CAPTURE_EN
  assign dp = dp_q;
`else
  logic unused_dp;
  assign unused_dp = ^dp_q;
`endif
endmodule
